// File: rtl/rom_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_read_arbiter_pkg
// Description : Shared types and helpers for the ROM read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_read_arbiter_pkg;

    // Arbiter controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Width of a binary requester id; never narrower than one bit
    function automatic int f_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : rom_read_arbiter_pkg
`default_nettype wire

// File: rtl/rom_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_read_arbiter_if
// Description : Request/response and ROM-side bus of the ROM read arbiter.
//               slave  = arbiter view, master = clients + ROM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_read_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int LEN_WIDTH     = 4
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_REQ*LEN_WIDTH-1:0]     req_len;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             rom_en;
    logic [ADDRESS_WIDTH-1:0]         rom_address;
    logic [DATA_WIDTH-1:0]            rom_data;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic                             rsp_last;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic                             busy;

    modport slave (
        input  req_valid, req_address, req_len, rom_data,
        output req_ready, rom_en, rom_address, rsp_valid, rsp_last, rsp_data, busy
    );

    modport master (
        output req_valid, req_address, req_len, rom_data,
        input  req_ready, rom_en, rom_address, rsp_valid, rsp_last, rsp_data, busy
    );
endinterface : rom_read_arbiter_if
`default_nettype wire

// File: rtl/rom_read_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Grants the first request
//               at or above i_ptr, wrapping around to requester 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [ID_W-1:0]    o_grant_id
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Rotating priority search starting at the pointer
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_read_arbiter
// Description : Shares one registered-read ROM between NUM_REQ clients with
//               round-robin arbitration and bursts of 1..2^LEN_WIDTH words.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int LEN_WIDTH     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rom_read_arbiter_if.slave bus
);

    localparam int ID_W = f_id_width(NUM_REQ);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ID_W-1:0]           r_rr_ptr;
    logic [ID_W-1:0]           r_owner;
    logic [ADDRESS_WIDTH-1:0]  r_cur_addr;
    logic [LEN_WIDTH-1:0]      r_remaining;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic                      r_rsp_last;

    logic [NUM_REQ-1:0]        w_grant;
    logic [ID_W-1:0]           w_grant_id;
    logic [ADDRESS_WIDTH-1:0]  w_addr_sel;
    logic [LEN_WIDTH-1:0]      w_len_sel;
    logic                      w_accept;
    logic                      w_issue;
    logic                      w_issue_last;
    logic [ID_W-1:0]           w_issue_id;
    logic                      w_rom_en;
    logic [ADDRESS_WIDTH-1:0]  w_rom_address;
    logic [NUM_REQ-1:0]        w_req_ready;
    logic [NUM_REQ-1:0]        w_rsp_valid_nxt;
    logic [ID_W-1:0]           w_ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req      (bus.req_valid),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // Winner's request fields, only meaningful in the accept cycle
    assign w_addr_sel = bus.req_address[int'(w_grant_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_len_sel  = bus.req_len[int'(w_grant_id)*LEN_WIDTH +: LEN_WIDTH];
    assign w_ptr_nxt  = (w_grant_id == ID_W'(NUM_REQ-1)) ? '0 : w_grant_id + ID_W'(1);

    // Next-state, ROM port drive and beat-issue decode
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_issue       = 1'b0;
        w_issue_last  = 1'b0;
        w_issue_id    = '0;
        w_rom_en      = 1'b0;
        w_rom_address = '0;
        w_req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                // Nothing is accepted while reset is held
                if ((|bus.req_valid) && !rst) begin
                    w_accept      = 1'b1;
                    w_req_ready   = w_grant;
                    w_rom_en      = 1'b1;
                    w_rom_address = w_addr_sel;
                    w_issue       = 1'b1;
                    w_issue_id    = w_grant_id;
                    w_issue_last  = (w_len_sel == '0);
                    if (w_len_sel != '0) begin
                        w_state_nxt = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                w_rom_en      = !rst;
                w_rom_address = r_cur_addr;
                w_issue       = !rst;
                w_issue_id    = r_owner;
                w_issue_last  = (r_remaining == LEN_WIDTH'(1));
                if (r_remaining == LEN_WIDTH'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-hot response strobe for the beat issued this cycle
    always_comb begin
        w_rsp_valid_nxt = '0;
        if (w_issue) begin
            w_rsp_valid_nxt[w_issue_id] = 1'b1;
        end
    end

    // Controller state and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    // Burst bookkeeping: owner, running address and beats still to issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= '0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_owner     <= w_grant_id;
            r_cur_addr  <= w_addr_sel + ADDRESS_WIDTH'(1);
            r_remaining <= w_len_sel;
        end else if (r_state == ST_BURST) begin
            r_cur_addr  <= r_cur_addr + ADDRESS_WIDTH'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
    end

    // Response pipeline aligned with the ROM's one-cycle read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_last  <= w_issue && w_issue_last;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.rom_en      = w_rom_en;
    assign bus.rom_address = w_rom_address;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_last    = r_rsp_last;
    assign bus.rsp_data    = bus.rom_data;
    assign bus.busy        = (r_state == ST_BURST);

endmodule : rom_read_arbiter
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_read_arbiter
// Description : Directed, table-driven bench for rom_read_arbiter with a
//               behavioural ROM holding mem[a] = a[7:0] ^ 8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_read_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DATA_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 10;
    localparam int LEN_WIDTH     = 4;

    // Start addresses: req3=0x200, req2=0x100, req1=0x3FE, req0=0x005
    localparam logic [39:0] c_ADDR = {10'h200, 10'h100, 10'h3FE, 10'h005};

    logic clk;
    logic rst;
    logic [DATA_WIDTH-1:0] r_rom_q;

    rom_read_arbiter_if #(
        .NUM_REQ       (NUM_REQ),
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH)
    ) bus ();

    rom_read_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] rom_word(input logic [9:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Behavioural ROM: enable-gated, one-cycle registered read
    always @(posedge clk) begin
        if (bus.rom_en) r_rom_q <= rom_word(bus.rom_address);
    end
    assign bus.rom_data = r_rom_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [15:0] len;
        logic [3:0]  e_ready;
        logic        e_en;
        logic [9:0]  e_addr;
        logic        e_busy;
        logic [3:0]  e_rsp;
        logic        e_last;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic [3:0] rv, input logic [15:0] len,
                       input logic [3:0] rdy, input logic en, input logic [9:0] ad,
                       input logic bsy, input logic [3:0] rsp, input logic lst,
                       input logic [7:0] dat);
        vec_t v;
        v.rst = r; v.rv = rv; v.len = len; v.e_ready = rdy; v.e_en = en;
        v.e_addr = ad; v.e_busy = bsy; v.e_rsp = rsp; v.e_last = lst; v.e_data = dat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        int beats;
        bit done;

        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_address = c_ADDR;
        bus.req_len     = '0;

        //   rst rv    len       ready en addr   busy rsp  last data
        add(1, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h0, 0, 8'h00); // reset state
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h0, 0, 8'h00);
        // single beat from req0
        add(0, 4'h1, 16'h0000, 4'h1, 1, 10'h005, 0, 4'h0, 0, 8'h00);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h1, 1, 8'hA0);
        // reset to restart the pointer, then all four requesting
        add(1, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h0, 0, 8'h00);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h0, 0, 8'h00);
        add(0, 4'hF, 16'h0000, 4'h1, 1, 10'h005, 0, 4'h0, 0, 8'h00);
        add(0, 4'hF, 16'h0000, 4'h2, 1, 10'h3FE, 0, 4'h1, 1, 8'hA0);
        add(0, 4'hF, 16'h0000, 4'h4, 1, 10'h100, 0, 4'h2, 1, 8'h5B);
        add(0, 4'hF, 16'h0000, 4'h8, 1, 10'h200, 0, 4'h4, 1, 8'hA5);
        add(0, 4'hF, 16'h0000, 4'h1, 1, 10'h005, 0, 4'h8, 1, 8'hA5);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h1, 1, 8'hA0);
        // req1 4-beat burst across the address wrap; req2 arrives mid-burst
        add(0, 4'h2, 16'h0030, 4'h2, 1, 10'h3FE, 0, 4'h0, 0, 8'h00);
        add(0, 4'h4, 16'h0030, 4'h0, 1, 10'h3FF, 1, 4'h2, 0, 8'h5B);
        add(0, 4'h4, 16'h0030, 4'h0, 1, 10'h000, 1, 4'h2, 0, 8'h5A);
        add(0, 4'h4, 16'h0030, 4'h0, 1, 10'h001, 1, 4'h2, 0, 8'hA5);
        add(0, 4'h4, 16'h0030, 4'h4, 1, 10'h100, 0, 4'h2, 1, 8'hA4);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h4, 1, 8'hA5);
        // req0 3-beat burst; req3 pulses once during it and is lost
        add(0, 4'h1, 16'h0002, 4'h1, 1, 10'h005, 0, 4'h0, 0, 8'h00);
        add(0, 4'h8, 16'h0002, 4'h0, 1, 10'h006, 1, 4'h1, 0, 8'hA0);
        add(0, 4'h0, 16'h0000, 4'h0, 1, 10'h007, 1, 4'h1, 0, 8'hA3);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h1, 1, 8'hA2);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h0, 0, 8'h00);
        // req2 6-beat burst cut by reset during its second beat
        add(0, 4'h4, 16'h0500, 4'h4, 1, 10'h100, 0, 4'h0, 0, 8'h00);
        add(1, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h0, 0, 8'h00);
        add(0, 4'hF, 16'h0000, 4'h1, 1, 10'h005, 0, 4'h0, 0, 8'h00);
        add(0, 4'h0, 16'h0000, 4'h0, 0, 10'h000, 0, 4'h1, 1, 8'hA0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.req_valid = vecs[i].rv;
            bus.req_len   = vecs[i].len;
            #1;
            chk($sformatf("row%0d req_ready", i),   32'(bus.req_ready),   32'(vecs[i].e_ready));
            chk($sformatf("row%0d rom_en", i),      32'(bus.rom_en),      32'(vecs[i].e_en));
            chk($sformatf("row%0d rom_address", i), 32'(bus.rom_address), 32'(vecs[i].e_addr));
            chk($sformatf("row%0d busy", i),        32'(bus.busy),        32'(vecs[i].e_busy));
            chk($sformatf("row%0d rsp_valid", i),   32'(bus.rsp_valid),   32'(vecs[i].e_rsp));
            chk($sformatf("row%0d rsp_last", i),    32'(bus.rsp_last),    32'(vecs[i].e_last));
            if (vecs[i].e_rsp != 4'h0)
                chk($sformatf("row%0d rsp_data", i), 32'(bus.rsp_data), 32'(vecs[i].e_data));
        end

        // Maximum-length burst (16 beats) from req1 across the address wrap
        @(negedge clk);
        bus.req_valid = 4'h2;
        bus.req_len   = 16'h00F0;
        #1;
        chk("maxlen accept req_ready", 32'(bus.req_ready),   32'h2);
        chk("maxlen accept address",   32'(bus.rom_address), 32'h3FE);
        @(negedge clk);
        bus.req_valid = 4'h0;
        bus.req_len   = 16'h0000;
        beats = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus.rsp_valid != 4'h0) begin
                chk($sformatf("maxlen beat%0d rsp_valid", beats), 32'(bus.rsp_valid), 32'h2);
                chk($sformatf("maxlen beat%0d rsp_data", beats), 32'(bus.rsp_data),
                    32'(rom_word(10'(10'h3FE + beats))));
                chk($sformatf("maxlen beat%0d rsp_last", beats), 32'(bus.rsp_last),
                    32'(beats == 15));
                beats++;
                if (bus.rsp_last) done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        chk("maxlen completed", 32'(done), 32'h1);
        chk("maxlen beat count", 32'(beats), 32'd16);
        chk("maxlen busy after", 32'(bus.busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_rom_read_arbiter
`default_nettype wire
